ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline. Feeds the memory stage through the 74-bit EX_MEM pipeline register.
- Selects forwarded operands, performs single-cycle ALU operations, and runs a 32-cycle iterative shift-add multiply (MUL).
- During a MUL it stalls the upstream stages and injects bubbles into EX_MEM.

---
 rtl/ex_pkg.sv | 40 ++++
 rtl/ex_multiplier.sv | 73 +++++++
 rtl/ex_stage.sv | 126 ++++++++++++
 tb/tb_ex_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forward selects,
// EX_MEM field positions (also used by the memory stage) and multiplier states.
package ex_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOR  = 4'd5,
      OP_SLL  = 4'd6,
      OP_SRL  = 4'd7,
      OP_SRA  = 4'd8,
      OP_SLT  = 4'd9,
      OP_SLTU = 4'd10,
      OP_LUI  = 4'd11,
      OP_MUL  = 4'd12
   } alu_op_e;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam int EXM_W            = 74;
   localparam int EXM_STORE_LSB    = 0;
   localparam int EXM_ALU_LSB      = 32;
   localparam int EXM_WREG_LSB     = 64;
   localparam int EXM_MEMREAD      = 69;
   localparam int EXM_MEMWRITE     = 70;
   localparam int EXM_REGWRITE     = 71;
   localparam int EXM_MEMTOREG_LSB = 72;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_BUSY = 2'd1,
      MS_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/ex_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles,
// then a single DONE cycle in which the product is valid.
module ex_multiplier
   import ex_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [DATA_W-1:0] i_multiplicand,
   input  logic [DATA_W-1:0] i_multiplier,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_product,
   output mul_state_e        o_state
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   mul_state_e        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [DATA_W-1:0] r_acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= MS_IDLE;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else begin
         case (r_state)
            MS_IDLE: begin
               if (i_start) begin
                  r_mcand  <= i_multiplicand;
                  r_mplier <= i_multiplier;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= MS_BUSY;
               end
            end
            MS_BUSY: begin
               if (i_abort) begin
                  r_cnt   <= '0;
                  r_state <= MS_IDLE;
               end else begin
                  if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_cnt    <= r_cnt + 1'b1;
                  if (r_cnt == CNT_LAST) r_state <= MS_DONE;
               end
            end
            default: begin
               // DONE (or an abort during DONE) always returns to IDLE.
               r_cnt   <= '0;
               r_state <= MS_IDLE;
            end
         endcase
      end
   end

   assign o_busy    = (r_state == MS_BUSY);
   assign o_done    = (r_state == MS_DONE);
   assign o_product = r_acc;
   assign o_state   = r_state;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL with
// upstream stall, and the EX_MEM pipeline register.
module ex_stage
   import ex_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              EX_Valid,
   input  logic [3:0]        EX_ALUOp,
   input  logic [DATA_W-1:0] EX_RegA,
   input  logic [DATA_W-1:0] EX_RegB,
   input  logic [DATA_W-1:0] EX_Imm,
   input  logic              EX_ALUSrc,
   input  logic [4:0]        EX_Shamt,
   input  logic              EX_ShiftVar,
   input  logic [1:0]        EX_ForwardA,
   input  logic [1:0]        EX_ForwardB,
   input  logic [DATA_W-1:0] EX_WBData,
   input  logic              EX_Flush,
   input  logic              EX_MemWrite,
   input  logic              EX_MemRead,
   input  logic              EX_RegWrite,
   input  logic [1:0]        EX_MemtoReg,
   input  logic [REG_W-1:0]  EX_WriteRegister,
   output logic              EX_Stall,
   output logic [EXM_W-1:0]  EX_MEM
);

   logic [EXM_W-1:0]  r_ex_mem;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_fwd_b;
   logic [DATA_W-1:0] w_op_b;
   logic [4:0]        w_sh;
   logic [DATA_W-1:0] w_alu;
   logic [DATA_W-1:0] w_result;
   logic [EXM_W-1:0]  w_ex_mem_next;
   logic              w_is_mul;
   logic              w_start;
   logic              w_bubble;
   logic              w_mul_busy;
   logic              w_mul_done;
   logic [DATA_W-1:0] w_mul_product;
   mul_state_e        w_mul_state;

   always_comb begin
      w_op_a = EX_RegA;
      case (EX_ForwardA)
         FWD_MEM: w_op_a = r_ex_mem[EXM_ALU_LSB +: DATA_W];
         FWD_WB:  w_op_a = EX_WBData;
         default: w_op_a = EX_RegA;
      endcase
      w_fwd_b = EX_RegB;
      case (EX_ForwardB)
         FWD_MEM: w_fwd_b = r_ex_mem[EXM_ALU_LSB +: DATA_W];
         FWD_WB:  w_fwd_b = EX_WBData;
         default: w_fwd_b = EX_RegB;
      endcase
   end

   assign w_op_b = EX_ALUSrc ? EX_Imm : w_fwd_b;
   assign w_sh   = EX_ShiftVar ? w_op_a[4:0] : EX_Shamt;

   always_comb begin
      w_alu = '0;
      case (EX_ALUOp)
         OP_ADD:  w_alu = w_op_a + w_op_b;
         OP_SUB:  w_alu = w_op_a - w_op_b;
         OP_AND:  w_alu = w_op_a & w_op_b;
         OP_OR:   w_alu = w_op_a | w_op_b;
         OP_XOR:  w_alu = w_op_a ^ w_op_b;
         OP_NOR:  w_alu = ~(w_op_a | w_op_b);
         OP_SLL:  w_alu = w_op_b << w_sh;
         OP_SRL:  w_alu = w_op_b >> w_sh;
         OP_SRA:  w_alu = $signed(w_op_b) >>> w_sh;
         OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
         OP_SLTU: w_alu = {{(DATA_W-1){1'b0}}, w_op_a < w_op_b};
         OP_LUI:  w_alu = {w_op_b[15:0], 16'h0000};
         default: w_alu = '0;
      endcase
   end

   assign w_is_mul = (EX_ALUOp == OP_MUL);
   assign w_start  = (w_mul_state == MS_IDLE) & EX_Valid & w_is_mul & ~EX_Flush & ~reset;

   ex_multiplier #(.DATA_W(DATA_W)) u_mul (
      .clk            (clk),
      .reset          (reset),
      .i_start        (w_start),
      .i_abort        (EX_Flush),
      .i_multiplicand (w_op_a),
      .i_multiplier   (w_op_b),
      .o_busy         (w_mul_busy),
      .o_done         (w_mul_done),
      .o_product      (w_mul_product),
      .o_state        (w_mul_state)
   );

   // A MUL only reaches EX_MEM in its DONE cycle; every earlier cycle is a bubble.
   assign w_bubble = ~EX_Valid | EX_Flush | w_mul_busy | (w_is_mul & ~w_mul_done);
   assign w_result = w_is_mul ? w_mul_product : w_alu;

   assign w_ex_mem_next = {EX_MemtoReg,
                           EX_RegWrite & (EX_WriteRegister != '0),
                           EX_MemWrite,
                           EX_MemRead,
                           EX_WriteRegister,
                           w_result,
                           w_fwd_b};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_mem <= '0;
      end else if (w_bubble) begin
         r_ex_mem <= '0;
      end else begin
         r_ex_mem <= w_ex_mem_next;
      end
   end

   assign EX_Stall = ~reset & (w_start | (w_mul_busy & ~EX_Flush));
   assign EX_MEM   = r_ex_mem;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: reset, forwarding, ALU ops, r0 writes,
// bubbles, store data, MUL latency, flush abort and back-to-back MULs.
module tb_ex_stage;

   logic        clk;
   logic        reset;
   logic        EX_Valid;
   logic [3:0]  EX_ALUOp;
   logic [31:0] EX_RegA;
   logic [31:0] EX_RegB;
   logic [31:0] EX_Imm;
   logic        EX_ALUSrc;
   logic [4:0]  EX_Shamt;
   logic        EX_ShiftVar;
   logic [1:0]  EX_ForwardA;
   logic [1:0]  EX_ForwardB;
   logic [31:0] EX_WBData;
   logic        EX_Flush;
   logic        EX_MemWrite;
   logic        EX_MemRead;
   logic        EX_RegWrite;
   logic [1:0]  EX_MemtoReg;
   logic [4:0]  EX_WriteRegister;
   logic        EX_Stall;
   logic [73:0] EX_MEM;

   int tests_run = 0;
   int tests_failed = 0;

   ex_stage dut (
      .clk              (clk),
      .reset            (reset),
      .EX_Valid         (EX_Valid),
      .EX_ALUOp         (EX_ALUOp),
      .EX_RegA          (EX_RegA),
      .EX_RegB          (EX_RegB),
      .EX_Imm           (EX_Imm),
      .EX_ALUSrc        (EX_ALUSrc),
      .EX_Shamt         (EX_Shamt),
      .EX_ShiftVar      (EX_ShiftVar),
      .EX_ForwardA      (EX_ForwardA),
      .EX_ForwardB      (EX_ForwardB),
      .EX_WBData        (EX_WBData),
      .EX_Flush         (EX_Flush),
      .EX_MemWrite      (EX_MemWrite),
      .EX_MemRead       (EX_MemRead),
      .EX_RegWrite      (EX_RegWrite),
      .EX_MemtoReg      (EX_MemtoReg),
      .EX_WriteRegister (EX_WriteRegister),
      .EX_Stall         (EX_Stall),
      .EX_MEM           (EX_MEM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      EX_Valid = 0; EX_ALUOp = 4'd0; EX_RegA = 0; EX_RegB = 0; EX_Imm = 0;
      EX_ALUSrc = 0; EX_Shamt = 0; EX_ShiftVar = 0; EX_ForwardA = 0; EX_ForwardB = 0;
      EX_WBData = 0; EX_Flush = 0; EX_MemWrite = 0; EX_MemRead = 0; EX_RegWrite = 0;
      EX_MemtoReg = 0; EX_WriteRegister = 0;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic alusrc, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [4:0] shamt, input logic shvar,
                        input logic [4:0] wr, input logic rw);
      EX_Valid = 1; EX_Flush = 0; EX_ALUOp = op; EX_RegA = a; EX_RegB = b; EX_Imm = imm;
      EX_ALUSrc = alusrc; EX_ForwardA = fa; EX_ForwardB = fb; EX_Shamt = shamt;
      EX_ShiftVar = shvar; EX_WriteRegister = wr; EX_RegWrite = rw;
      EX_MemWrite = 0; EX_MemRead = 0; EX_MemtoReg = 0;
   endtask

   // Steps through a MUL already presented; stops in the first non-stall cycle.
   task automatic run_mul_wait(output int stall_cycles, output int bubble_bad);
      stall_cycles = 0;
      bubble_bad = 0;
      while (EX_Stall === 1'b1 && stall_cycles < 40) begin
         stall_cycles++;
         tick();
         if (EX_MEM !== 74'd0) bubble_bad++;
      end
   endtask

   task automatic test_reset();
      reset = 1;
      idle();
      tick(); tick();
      tests_run++;
      if (EX_MEM !== 74'd0) begin
         tests_failed++;
         $display("FAIL reset_ex_mem: got %h expected 0", EX_MEM);
      end
      tests_run++;
      if (EX_Stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_stall: got %b expected 0", EX_Stall);
      end
      reset = 0;
   endtask

   task automatic test_reset_mid_mul();
      int n, bad;
      drive(4'd12, 32'hFFFFFFFF, 32'd3, 0, 0, 2'b00, 2'b00, 0, 0, 5'd5, 1);
      repeat (5) tick();
      reset = 1;
      #1;
      tests_run++;
      if (EX_Stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_mul_stall: got %b expected 0", EX_Stall);
      end
      tick(); tick();
      tests_run++;
      if (EX_MEM !== 74'd0 || EX_Stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_mul_state: ex_mem %h stall %b expected 0 0", EX_MEM, EX_Stall);
      end
      reset = 0;
      drive(4'd12, 32'd6, 32'd7, 0, 0, 2'b00, 2'b00, 0, 0, 5'd3, 1);
      #1;
      run_mul_wait(n, bad);
      tests_run++;
      if (n !== 33 || bad !== 0) begin
         tests_failed++;
         $display("FAIL post_reset_mul_stall: got %0d cycles %0d bad bubbles expected 33 0", n, bad);
      end
      tick();
      tests_run++;
      if (EX_MEM !== {2'b00, 1'b1, 1'b0, 1'b0, 5'd3, 32'd42, 32'd7}) begin
         tests_failed++;
         $display("FAIL post_reset_mul_result: got %h expected %h", EX_MEM,
                  {2'b00, 1'b1, 1'b0, 1'b0, 5'd3, 32'd42, 32'd7});
      end
      idle();
      tick();
   endtask

   task automatic test_add_forward();
      drive(4'd0, 32'd100, 32'd0, 0, 0, 2'b00, 2'b00, 0, 0, 5'd1, 1);
      tick();
      tests_run++;
      if (EX_MEM[63:32] !== 32'd100) begin
         tests_failed++;
         $display("FAIL add_base: got %0d expected 100", EX_MEM[63:32]);
      end
      drive(4'd0, 32'd5, 32'd0, 32'd7, 1, 2'b01, 2'b00, 0, 0, 5'd2, 1);
      tick();
      tests_run++;
      if (EX_MEM[63:32] !== 32'd107) begin
         tests_failed++;
         $display("FAIL add_fwd_mem: got %0d expected 107", EX_MEM[63:32]);
      end
      // ForwardB code 11 must fall back to the register value.
      drive(4'd0, 32'd1, 32'd2, 0, 0, 2'b00, 2'b11, 0, 0, 5'd2, 1);
      EX_WBData = 32'hDEADBEEF;
      tick();
      tests_run++;
      if (EX_MEM[63:0] !== {32'd3, 32'd2}) begin
         tests_failed++;
         $display("FAIL fwd_b_11: got %h expected %h", EX_MEM[63:0], {32'd3, 32'd2});
      end
   endtask

   task automatic test_alu_ops();
      logic [3:0]  t_op[12];
      logic [31:0] t_a[12];
      logic [31:0] t_b[12];
      logic [31:0] t_imm[12];
      logic        t_src[12];
      logic [4:0]  t_sh[12];
      logic        t_var[12];
      logic [31:0] t_exp[12];
      t_op  = '{4'd8, 4'd7, 4'd6, 4'd10, 4'd9, 4'd1, 4'd5, 4'd4, 4'd2, 4'd3, 4'd11, 4'd15};
      t_a   = '{32'd0, 32'd4, 32'd0, 32'd1, 32'd1, 32'd3, 32'hF0F0F0F0, 32'hFF00FF00,
                32'hFF00FF00, 32'hFF00FF00, 32'd0, 32'd5};
      t_b   = '{32'h80000000, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5,
                32'h0F0F0000, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'd0, 32'd5};
      t_imm = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                32'h00001234, 32'd0};
      t_src = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      t_sh  = '{5'd4, 5'd0, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      t_var = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      t_exp = '{32'hF8000000, 32'h08000000, 32'h80000000, 32'd1, 32'd0, 32'hFFFFFFFE,
                32'h00000F0F, 32'hF0F0F0F0, 32'h0F000F00, 32'hFFF0FFF0, 32'h12340000, 32'd0};
      for (int i = 0; i < 12; i++) begin
         drive(t_op[i], t_a[i], t_b[i], t_imm[i], t_src[i], 2'b00, 2'b00, t_sh[i], t_var[i],
               5'd9, 1);
         tick();
         tests_run++;
         if (EX_MEM[63:32] !== t_exp[i]) begin
            tests_failed++;
            $display("FAIL alu_op%0d: got %h expected %h", t_op[i], EX_MEM[63:32], t_exp[i]);
         end
      end
   endtask

   task automatic test_r0_and_bubbles();
      drive(4'd0, 32'd1, 32'd1, 0, 0, 2'b00, 2'b00, 0, 0, 5'd0, 1);
      tick();
      tests_run++;
      if (EX_MEM[71] !== 1'b0 || EX_MEM[68:64] !== 5'd0 || EX_MEM[63:32] !== 32'd2) begin
         tests_failed++;
         $display("FAIL r0_write: got regwrite %b wr %0d result %0d expected 0 0 2",
                  EX_MEM[71], EX_MEM[68:64], EX_MEM[63:32]);
      end
      drive(4'd0, 32'd1, 32'd1, 0, 0, 2'b00, 2'b00, 0, 0, 5'd4, 1);
      EX_Valid = 0;
      tick();
      tests_run++;
      if (EX_MEM !== 74'd0) begin
         tests_failed++;
         $display("FAIL invalid_bubble: got %h expected 0", EX_MEM);
      end
      drive(4'd0, 32'd1, 32'd1, 0, 0, 2'b00, 2'b00, 0, 0, 5'd4, 1);
      EX_Flush = 1;
      tick();
      tests_run++;
      if (EX_MEM !== 74'd0) begin
         tests_failed++;
         $display("FAIL flush_bubble: got %h expected 0", EX_MEM);
      end
   endtask

   task automatic test_store();
      drive(4'd0, 32'h1000, 32'h11111111, 32'd8, 1, 2'b00, 2'b10, 0, 0, 5'd0, 0);
      EX_MemWrite = 1;
      EX_WBData = 32'hDEADBEEF;
      tick();
      tests_run++;
      if (EX_MEM !== {2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 32'h00001008, 32'hDEADBEEF}) begin
         tests_failed++;
         $display("FAIL store_data: got %h expected %h", EX_MEM,
                  {2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 32'h00001008, 32'hDEADBEEF});
      end
   endtask

   task automatic test_mul_back_to_back();
      int n, bad;
      drive(4'd12, 32'hFFFFFFFF, 32'd3, 0, 0, 2'b00, 2'b00, 0, 0, 5'd5, 1);
      #1;
      run_mul_wait(n, bad);
      tests_run++;
      if (n !== 33 || bad !== 0) begin
         tests_failed++;
         $display("FAIL mul_stall: got %0d cycles %0d bad bubbles expected 33 0", n, bad);
      end
      tick();
      tests_run++;
      if (EX_MEM !== {2'b00, 1'b1, 1'b0, 1'b0, 5'd5, 32'hFFFFFFFD, 32'd3}) begin
         tests_failed++;
         $display("FAIL mul_result: got %h expected %h", EX_MEM,
                  {2'b00, 1'b1, 1'b0, 1'b0, 5'd5, 32'hFFFFFFFD, 32'd3});
      end
      drive(4'd12, 32'd12345, 32'h00010000, 0, 0, 2'b00, 2'b00, 0, 0, 5'd6, 1);
      #1;
      tests_run++;
      if (EX_Stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_start: got stall %b expected 1", EX_Stall);
      end
      run_mul_wait(n, bad);
      tick();
      tests_run++;
      if (n !== 33 || bad !== 0 || EX_MEM[63:32] !== 32'h30390000) begin
         tests_failed++;
         $display("FAIL b2b_result: got %0d cycles %0d bad result %h expected 33 0 30390000",
                  n, bad, EX_MEM[63:32]);
      end
      idle();
      tick();
   endtask

   task automatic test_flush_mid_mul();
      drive(4'd12, 32'd9, 32'd9, 0, 0, 2'b00, 2'b00, 0, 0, 5'd8, 1);
      repeat (11) tick();
      tests_run++;
      if (EX_Stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_pre_stall: got %b expected 1", EX_Stall);
      end
      EX_Flush = 1;
      #1;
      tests_run++;
      if (EX_Stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_stall_drop: got %b expected 0", EX_Stall);
      end
      tick();
      tests_run++;
      if (EX_MEM !== 74'd0) begin
         tests_failed++;
         $display("FAIL flush_mul_bubble: got %h expected 0", EX_MEM);
      end
      drive(4'd0, 32'd2, 32'd3, 0, 0, 2'b00, 2'b00, 0, 0, 5'd7, 1);
      #1;
      tests_run++;
      if (EX_Stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_then_add_stall: got %b expected 0", EX_Stall);
      end
      tick();
      tests_run++;
      if (EX_MEM !== {2'b00, 1'b1, 1'b0, 1'b0, 5'd7, 32'd5, 32'd3}) begin
         tests_failed++;
         $display("FAIL flush_then_add: got %h expected %h", EX_MEM,
                  {2'b00, 1'b1, 1'b0, 1'b0, 5'd7, 32'd5, 32'd3});
      end
      idle();
      tick();
   endtask

   initial begin
      test_reset();
      test_add_forward();
      test_alu_ops();
      test_r0_and_bubbles();
      test_store();
      test_mul_back_to_back();
      test_flush_mid_mul();
      test_reset_mid_mul();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
